serial_tx: RTL

Parallel-in, serial-out asynchronous-frame transmitter. It accepts one data word per valid/ready handshake and drives it onto a single line as a frame: start bit, data bits LSB first, optional even parity bit, one stop bit. It is the transmit end of the team's serial link; the matching serial receiver samples this line. It sits between a register-file or FIFO producer and the pad/line driver.

---
 rtl/serial_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data,
// optional even parity, one stop bit. All outputs are registered.
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_valid_in,
  output logic                  tx_ready_out,
  output logic                  serial_out,
  output logic                  busy_out,
  output logic                  tx_done_out,
  output logic [2:0]            state
);

  // Handshake: a word is taken on a rising edge where tx_valid_in and
  // tx_ready_out are both high; the producer holds valid/data until then.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  state_t                cur, nxt;
  logic [CW-1:0]         cnt, cnt_n;
  logic [IW-1:0]         idx, idx_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  par, par_n;
  logic                  serial_n, ready_n, done_n;
  logic                  last;

  assign state = cur;
  assign last  = (cnt == CNT_LAST);

  always_comb begin
    nxt      = cur;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    par_n    = par;
    serial_n = serial_out;
    ready_n  = tx_ready_out;
    done_n   = 1'b0;
    case (cur)
      IDLE: begin
        serial_n = 1'b1;
        ready_n  = 1'b1;
        if (tx_valid_in && tx_ready_out) begin
          shift_n  = tx_data_in;
          par_n    = ^tx_data_in;
          nxt      = START;
          cnt_n    = '0;
          serial_n = 1'b0;
          ready_n  = 1'b0;
        end
      end
      START: begin
        if (last) begin
          cnt_n    = '0;
          idx_n    = '0;
          nxt      = DATA;
          serial_n = shift[0];
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (last) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              nxt      = PARITY;
              serial_n = par;
            end else begin
              nxt      = STOP;
              serial_n = 1'b1;
            end
          end else begin
            // The next line bit is the one about to land in bit 0.
            idx_n    = idx + IW'(1);
            shift_n  = shift >> 1;
            serial_n = shift[1];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PARITY: begin
        if (last) begin
          cnt_n    = '0;
          nxt      = STOP;
          serial_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (last) begin
          cnt_n    = '0;
          nxt      = IDLE;
          serial_n = 1'b1;
          ready_n  = 1'b1;
          done_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        nxt      = IDLE;
        cnt_n    = '0;
        serial_n = 1'b1;
        ready_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur          <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      par          <= 1'b0;
      serial_out   <= 1'b1;
      tx_ready_out <= 1'b1;
      busy_out     <= 1'b0;
      tx_done_out  <= 1'b0;
    end else begin
      cur          <= nxt;
      cnt          <= cnt_n;
      idx          <= idx_n;
      shift        <= shift_n;
      par          <= par_n;
      serial_out   <= serial_n;
      tx_ready_out <= ready_n;
      busy_out     <= ~ready_n;
      tx_done_out  <= done_n;
    end
  end

endmodule
